// File: rtl/dispatch_pkg.sv
// dispatch_pkg: shared types and widths for the rename->dispatch skid buffer.
//   skid_state_t : buffer occupancy state (encoding equals the bundle count)
//   BUNDLE_W     : renamed-instruction bundle width
//   STALL_CNT_W  : rename stall-cycle counter width
package dispatch_pkg;
  localparam int BUNDLE_W    = 219;
  localparam int STALL_CNT_W = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;
endpackage

// File: rtl/payload_reg.sv
// payload_reg: WIDTH-wide data register with load enable, async active-high
// reset to zero.
//   clk, reset : clock / async reset
//   en         : load d on the rising edge
//   d, q       : data in / registered data out
module payload_reg #(
  parameter int WIDTH = 219
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/dispatch_skid_buffer.sv
// dispatch_skid_buffer: two-entry elastic buffer between rename and dispatch.
// in_ready comes from the state register only, cutting the combinational
// back-pressure path from dispatch to rename.
//   clk, reset            : clock / async active-high reset
//   flush                 : synchronous squash of all held bundles
//   in_valid/in_ready/in_data    : rename-side handshake
//   out_valid/out_ready/out_data : dispatch-side handshake
//   occupancy             : held bundles (0..2)
//   stall_cycles          : saturating count of in_valid && !in_ready cycles
module dispatch_skid_buffer
  import dispatch_pkg::*;
#(
  parameter int WIDTH     = BUNDLE_W,
  parameter int CNT_WIDTH = STALL_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [1:0]           occupancy,
  output logic [CNT_WIDTH-1:0] stall_cycles
);
  skid_state_t          state_q, state_d;
  logic [CNT_WIDTH-1:0] stall_q, stall_d;
  logic [WIDTH-1:0]     main_q, skid_q, main_d;
  logic                 main_en, skid_en;
  logic                 accept, take;

  // Reset gating keeps rename from handing over a bundle while the
  // buffer is being cleared.
  assign in_ready  = !reset && (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready;
  assign take      = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    skid_en = 1'b0;
    main_d  = in_data;
    case (state_q)
      EMPTY: if (accept) begin
        state_d = ONE;
        main_en = 1'b1;
      end
      ONE: begin
        if (accept && take) begin
          main_en = 1'b1;
        end else if (accept) begin
          state_d = FULL;
          skid_en = 1'b1;
        end else if (take) begin
          state_d = EMPTY;
        end
      end
      FULL: if (take) begin
        // Skid bundle is the younger one; it moves up behind the take.
        state_d = ONE;
        main_en = 1'b1;
        main_d  = skid_q;
      end
      default: state_d = EMPTY;
    endcase
    // Flush wins: offered bundle is dropped, a concurrent take still completes.
    if (flush) begin
      state_d = EMPTY;
      main_en = 1'b0;
      skid_en = 1'b0;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (in_valid && !in_ready && (stall_q != '1))
      stall_d = stall_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  payload_reg #(.WIDTH(WIDTH)) u_main (
    .clk(clk), .reset(reset), .en(main_en), .d(main_d), .q(main_q)
  );

  payload_reg #(.WIDTH(WIDTH)) u_skid (
    .clk(clk), .reset(reset), .en(skid_en), .d(in_data), .q(skid_q)
  );

  always_comb begin
    case (state_q)
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  assign out_data     = main_q;
  assign stall_cycles = stall_q;
endmodule

// File: tb/tb_dispatch_skid_buffer.sv
module tb_dispatch_skid_buffer;
  localparam int W = 219;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [1:0]    occupancy;
  logic [31:0]   stall_cycles;

  // Narrow-counter instance for saturation checks.
  logic          s_flush = 1'b0;
  logic          s_in_valid = 1'b0;
  logic          s_in_ready;
  logic [7:0]    s_in_data = '0;
  logic          s_out_valid;
  logic          s_out_ready = 1'b0;
  logic [7:0]    s_out_data;
  logic [1:0]    s_occupancy;
  logic [3:0]    s_stall_cycles;

  int chk = 0;
  int pass = 0;

  // Reference model: a FIFO of at most two bundles plus a stall count.
  logic [W-1:0] mq[$];
  longint       m_stall = 0;

  always #5 clk = ~clk;

  dispatch_skid_buffer dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cycles(stall_cycles)
  );

  dispatch_skid_buffer #(.WIDTH(8), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .reset(reset), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .occupancy(s_occupancy), .stall_cycles(s_stall_cycles)
  );

  // Advance the model by one edge using the currently driven inputs,
  // then wait for the edge and settle to the sampling point.
  task automatic cyc();
    bit acc, tk;
    acc = in_valid && (mq.size() < 2);
    tk  = (mq.size() > 0) && out_ready;
    if (in_valid && mq.size() == 2) m_stall++;
    if (tk) void'(mq.pop_front());
    if (flush) mq.delete();
    else if (acc) mq.push_back(in_data);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    flush = 0; in_valid = 0; out_ready = 0;
    s_flush = 0; s_in_valid = 0; s_out_ready = 0;
    reset = 1;
    mq.delete();
    m_stall = 0;
    repeat (2) @(posedge clk);
    #3 reset = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    chk++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%0b exp=0", in_ready); else pass++;
    chk++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0b exp=0", out_valid); else pass++;
    chk++; if (occupancy !== 2'd0) $display("FAIL reset_occ got=%0d exp=0", occupancy); else pass++;
    chk++; if (out_data !== '0) $display("FAIL reset_out_data got=%h exp=0", out_data); else pass++;
    chk++; if (stall_cycles !== 32'd0) $display("FAIL reset_stall got=%0d exp=0", stall_cycles); else pass++;
    @(negedge clk);
    reset = 0;
    @(posedge clk); #1;
    chk++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready got=%0b exp=1", in_ready); else pass++;
    chk++; if (out_valid !== 1'b0) $display("FAIL post_reset_out_valid got=%0b exp=0", out_valid); else pass++;
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1;
    in_valid  = 1;
    for (int k = 1; k <= 4; k++) begin
      in_data = W'(k);
      cyc();
      chk++; if (out_data !== W'(k) || out_valid !== 1'b1)
        $display("FAIL stream_data k=%0d got=%h v=%0b exp=%0d", k, out_data, out_valid, k); else pass++;
      chk++; if (occupancy !== 2'd1) $display("FAIL stream_occ got=%0d exp=1", occupancy); else pass++;
    end
    in_valid = 0;
    cyc();
    chk++; if (out_valid !== 1'b0) $display("FAIL stream_drain got=%0b exp=0", out_valid); else pass++;
    chk++; if (stall_cycles !== 32'd0) $display("FAIL stream_stall got=%0d exp=0", stall_cycles); else pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 0;
    in_valid  = 1;
    in_data = W'('hA); cyc();
    in_data = W'('hB); cyc();
    chk++; if (occupancy !== 2'd2) $display("FAIL bp_occ got=%0d exp=2", occupancy); else pass++;
    chk++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got=%0b exp=0", in_ready); else pass++;
    in_data = W'('hC);
    repeat (5) cyc();
    chk++; if (stall_cycles !== 32'd5) $display("FAIL bp_stall got=%0d exp=5", stall_cycles); else pass++;
    in_valid = 0;
    out_ready = 1;
    chk++; if (out_data !== W'('hA)) $display("FAIL bp_first got=%h exp=a", out_data); else pass++;
    cyc();
    chk++; if (out_data !== W'('hB) || occupancy !== 2'd1)
      $display("FAIL bp_second got=%h occ=%0d exp=b occ=1", out_data, occupancy); else pass++;
    chk++; if (in_ready !== 1'b1) $display("FAIL bp_recover got=%0b exp=1", in_ready); else pass++;
    cyc();
    chk++; if (out_valid !== 1'b0) $display("FAIL bp_empty got=%0b exp=0", out_valid); else pass++;
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 0;
    in_valid  = 1;
    in_data = W'('hA); cyc();
    in_data = W'('hB); cyc();
    flush = 1; out_ready = 1; in_data = W'('hC);
    chk++; if (out_valid !== 1'b1 || out_data !== W'('hA))
      $display("FAIL flush_take got=%h v=%0b exp=a", out_data, out_valid); else pass++;
    cyc();
    flush = 0; in_valid = 0;
    chk++; if (out_valid !== 1'b0 || occupancy !== 2'd0)
      $display("FAIL flush_empty v=%0b occ=%0d exp=0", out_valid, occupancy); else pass++;
    chk++; if (in_ready !== 1'b1) $display("FAIL flush_ready got=%0b exp=1", in_ready); else pass++;
    chk++; if (stall_cycles !== 32'(m_stall)) $display("FAIL flush_stall got=%0d exp=%0d", stall_cycles, m_stall); else pass++;
    repeat (3) begin
      cyc();
      chk++; if (out_valid !== 1'b0) $display("FAIL flush_dropped got=%h v=%0b", out_data, out_valid); else pass++;
    end
  endtask

  task automatic test_random();
    int unsigned seq = 1;
    int unsigned exp_out = 1;
    bit r0;
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = $urandom_range(0, 1);
      in_data   = W'({7{seq}});
      if (out_valid && out_ready) begin
        chk++; if (out_data[31:0] !== exp_out)
          $display("FAIL rand_order i=%0d got=%0d exp=%0d", i, out_data[31:0], exp_out); else pass++;
        exp_out++;
      end
      if (in_valid && mq.size() < 2) seq++;
      cyc();
      chk++; if (occupancy !== 2'(mq.size()) || out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2))
        $display("FAIL rand_state i=%0d occ=%0d v=%0b r=%0b exp_occ=%0d", i, occupancy, out_valid, in_ready, mq.size());
      else pass++;
      if (mq.size() > 0) begin
        chk++; if (out_data !== mq[0]) $display("FAIL rand_data i=%0d got=%h exp=%h", i, out_data, mq[0]); else pass++;
      end
      if (i % 10 == 0) begin
        r0 = in_ready;
        out_ready = ~out_ready;
        #1;
        chk++; if (in_ready !== r0) $display("FAIL rand_comb_path i=%0d got=%0b exp=%0b", i, in_ready, r0); else pass++;
        out_ready = ~out_ready;
      end
    end
    chk++; if (stall_cycles !== 32'(m_stall)) $display("FAIL rand_stall got=%0d exp=%0d", stall_cycles, m_stall); else pass++;
  endtask

  task automatic test_saturation();
    int exp;
    do_reset();
    s_in_valid = 1;
    s_out_ready = 0;
    s_in_data = 8'h5A;
    for (int n = 1; n <= 22; n++) begin
      cyc();
      if (n == 2 || n == 5 || n == 16 || n == 17 || n == 22) begin
        exp = (n < 2) ? 0 : ((n - 2 > 15) ? 15 : n - 2);
        chk++; if (s_stall_cycles !== 4'(exp))
          $display("FAIL sat_count n=%0d got=%0d exp=%0d", n, s_stall_cycles, exp); else pass++;
      end
    end
    chk++; if (s_in_ready !== 1'b0 || s_out_data !== 8'h5A)
      $display("FAIL sat_full r=%0b d=%h exp r=0 d=5a", s_in_ready, s_out_data); else pass++;
    s_in_valid = 0;
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 0;
    in_valid  = 1;
    in_data = W'('h11); cyc();
    in_data = W'('h22); cyc();
    in_valid = 0;
    chk++; if (occupancy !== 2'd2) $display("FAIL ar_pre_occ got=%0d exp=2", occupancy); else pass++;
    #3 reset = 1;
    mq.delete();
    m_stall = 0;
    #1;
    chk++; if (out_valid !== 1'b0 || occupancy !== 2'd0)
      $display("FAIL ar_state v=%0b occ=%0d exp=0", out_valid, occupancy); else pass++;
    chk++; if (out_data !== '0) $display("FAIL ar_data got=%h exp=0", out_data); else pass++;
    chk++; if (in_ready !== 1'b0) $display("FAIL ar_in_ready got=%0b exp=0", in_ready); else pass++;
    @(negedge clk);
    #2 reset = 0;
    cyc();
    chk++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL ar_release r=%0b v=%0b exp r=1 v=0", in_ready, out_valid); else pass++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_random();
    test_saturation();
    test_async_reset();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
